// File: rtl/sram_arbiter_pkg.sv
// Shared types, constants and helpers for the two-port SRAM arbiter.
package sram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;

    // Wide enough for the longest phase (WAIT_MAX + 2 cycles).
    localparam int CNT_W = 5;

    function automatic bit wait_states_ok(input int w);
        return (w >= WAIT_MIN) && (w <= WAIT_MAX);
    endfunction

    // Cycles spent on one halfword of a read.
    function automatic logic [CNT_W-1:0] rd_phase_len(input int w);
        return CNT_W'(w + 1);
    endfunction

    // Cycles spent on one halfword of a write: setup, strobe, hold.
    function automatic logic [CNT_W-1:0] wr_phase_len(input int w);
        return CNT_W'(w + 2);
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant; the pointer moves only when a grant is accepted.
module sram_rr_arbiter
    import sram_arbiter_pkg::*;
(
    input  logic       clk_sys,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    // Index of the port that won most recently; reset value makes port 0 favoured.
    logic last_gnt;

    // Single requester wins outright; on contention the port not served last wins.
    always_comb begin
        gnt = 2'b00;
        if (req[PORT0] && req[PORT1]) begin
            if (last_gnt) begin
                gnt[PORT0] = 1'b1;
            end else begin
                gnt[PORT1] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

    // Remember the winner of each accepted grant.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (accept) begin
            last_gnt <= gnt[PORT1];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one 256Kx16 async SRAM between two 32-bit word masters; each word is
// two halfword cycles with programmable wait states and registered pad outputs.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic        io_mainClk,
    input  logic        io_asyncReset,

    input  logic        p0_cmd_valid,
    output logic        p0_cmd_ready,
    input  logic        p0_cmd_write,
    input  logic [16:0] p0_cmd_address,
    input  logic [31:0] p0_cmd_data,
    input  logic [3:0]  p0_cmd_mask,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rsp_data,

    input  logic        p1_cmd_valid,
    output logic        p1_cmd_ready,
    input  logic        p1_cmd_write,
    input  logic [16:0] p1_cmd_address,
    input  logic [31:0] p1_cmd_data,
    input  logic [3:0]  p1_cmd_mask,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rsp_data,

    output logic        io_sram_cs,
    output logic        io_sram_we,
    output logic        io_sram_oe,
    output logic        io_sram_bhe,
    output logic        io_sram_ble,
    output logic [17:0] io_sram_addr,
    inout  wire  [15:0] io_sram_dat
);

    if (!wait_states_ok(WAIT_STATES)) begin : g_bad_wait_states
        $error("sram_arbiter: WAIT_STATES must be within 1..15");
    end

    // Counter reload values: the phase runs while the counter walks down to zero.
    localparam logic [CNT_W-1:0] RD_LOAD = rd_phase_len(WAIT_STATES) - CNT_W'(1);
    localparam logic [CNT_W-1:0] WR_LOAD = wr_phase_len(WAIT_STATES) - CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              owner;
    logic [16:0]       addr_q;
    logic [15:0]       data_hi_q;
    logic [1:0]        mask_hi_q;
    logic [31:0]       rd_buf;
    logic [1:0]        rsp_valid_q;
    logic              dat_oe;
    logic [15:0]       dat_out;

    logic [1:0]        gnt;
    logic              accept;
    logic              sel_port;
    logic              sel_write;
    logic [16:0]       sel_addr;
    logic [31:0]       sel_data;
    logic [3:0]        sel_mask;

    sram_rr_arbiter u_rr (
        .clk_sys (io_mainClk),
        .rst     (io_asyncReset),
        .req     ({p1_cmd_valid, p0_cmd_valid}),
        .accept  (accept),
        .gnt     (gnt)
    );

    // Grants are only taken in IDLE; ready is held low while reset is asserted.
    assign accept       = (state == ST_IDLE) && (gnt != 2'b00);
    assign p0_cmd_ready = accept && gnt[PORT0] && !io_asyncReset;
    assign p1_cmd_ready = accept && gnt[PORT1] && !io_asyncReset;

    assign sel_port  = gnt[PORT1];
    assign sel_write = sel_port ? p1_cmd_write   : p0_cmd_write;
    assign sel_addr  = sel_port ? p1_cmd_address : p0_cmd_address;
    assign sel_data  = sel_port ? p1_cmd_data    : p0_cmd_data;
    assign sel_mask  = sel_port ? p1_cmd_mask    : p0_cmd_mask;

    // One read buffer serves both ports; its content matters only during rsp_valid.
    assign p0_rsp_valid = rsp_valid_q[PORT0];
    assign p1_rsp_valid = rsp_valid_q[PORT1];
    assign p0_rsp_data  = rd_buf;
    assign p1_rsp_data  = rd_buf;

    assign io_sram_dat = dat_oe ? dat_out : 16'hzzzz;

    // Access sequencer; every pad output is registered here one cycle ahead of its phase.
    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            owner        <= 1'b0;
            addr_q       <= '0;
            data_hi_q    <= '0;
            mask_hi_q    <= '0;
            rd_buf       <= '0;
            rsp_valid_q  <= 2'b00;
            io_sram_cs   <= 1'b1;
            io_sram_we   <= 1'b1;
            io_sram_oe   <= 1'b1;
            io_sram_bhe  <= 1'b1;
            io_sram_ble  <= 1'b1;
            io_sram_addr <= '0;
            dat_oe       <= 1'b0;
            dat_out      <= '0;
        end else begin
            rsp_valid_q <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner        <= sel_port;
                        addr_q       <= sel_addr;
                        data_hi_q    <= sel_data[31:16];
                        mask_hi_q    <= sel_mask[3:2];
                        io_sram_cs   <= 1'b0;
                        io_sram_we   <= 1'b1;
                        io_sram_addr <= {sel_addr, 1'b0};
                        if (sel_write) begin
                            state       <= ST_WR_LO;
                            cnt         <= WR_LOAD;
                            io_sram_oe  <= 1'b1;
                            io_sram_ble <= ~sel_mask[0];
                            io_sram_bhe <= ~sel_mask[1];
                            dat_oe      <= 1'b1;
                            dat_out     <= sel_data[15:0];
                        end else begin
                            state       <= ST_RD_LO;
                            cnt         <= RD_LOAD;
                            io_sram_oe  <= 1'b0;
                            io_sram_ble <= 1'b0;
                            io_sram_bhe <= 1'b0;
                        end
                    end
                end
                ST_RD_LO: begin
                    if (cnt == '0) begin
                        rd_buf[15:0] <= io_sram_dat;
                        state        <= ST_RD_HI;
                        cnt          <= RD_LOAD;
                        io_sram_addr <= {addr_q, 1'b1};
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RD_HI: begin
                    if (cnt == '0) begin
                        rd_buf[31:16]      <= io_sram_dat;
                        state              <= ST_DONE;
                        rsp_valid_q[owner] <= 1'b1;
                        io_sram_cs         <= 1'b1;
                        io_sram_oe         <= 1'b1;
                        io_sram_bhe        <= 1'b1;
                        io_sram_ble        <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WR_LO: begin
                    if (cnt == '0) begin
                        state        <= ST_WR_HI;
                        cnt          <= WR_LOAD;
                        io_sram_we   <= 1'b1;
                        io_sram_addr <= {addr_q, 1'b1};
                        io_sram_ble  <= ~mask_hi_q[0];
                        io_sram_bhe  <= ~mask_hi_q[1];
                        dat_out      <= data_hi_q;
                    end else begin
                        // we is low for the counts between setup and the final hold cycle.
                        cnt        <= cnt - CNT_W'(1);
                        io_sram_we <= (cnt < CNT_W'(2));
                    end
                end
                ST_WR_HI: begin
                    if (cnt == '0) begin
                        state              <= ST_DONE;
                        rsp_valid_q[owner] <= 1'b1;
                        io_sram_cs         <= 1'b1;
                        io_sram_we         <= 1'b1;
                        io_sram_bhe        <= 1'b1;
                        io_sram_ble        <= 1'b1;
                        dat_oe             <= 1'b0;
                    end else begin
                        cnt        <= cnt - CNT_W'(1);
                        io_sram_we <= (cnt < CNT_W'(2));
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
